hgcal_input_quantizer: RTL and testbench

Front-end stage of the HGCAL autoencoder LUT network. Takes a serial stream of raw unsigned cell energies, quantizes each to a QBITS-wide code with a saturating offset/shift rule, and packs one frame of NUM_FEATURES codes into the flat input vector consumed by the layer-0 neuron LUTs. It double-buffers frames so the next frame can fill while the previous one waits on downstream backpressure. It also detects frame-length errors and resynchronises after them.

---
 rtl/hgcal_quant_pkg.sv | 22 ++
 rtl/hgcal_input_quantizer_if.sv | 28 ++
 rtl/hgcal_feature_quantizer.sv | 27 ++
 rtl/hgcal_input_quantizer.sv | 136 +++++++++++++
 tb/tb_hgcal_input_quantizer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hgcal_quant_pkg.sv
// Shared defaults, FSM state type and code-range helpers for the HGCAL input quantizer.
package hgcal_quant_pkg;

    localparam int unsigned DefaultInWidth     = 16;
    localparam int unsigned DefaultNumFeatures = 48;
    localparam int unsigned DefaultQbits       = 2;

    // Largest code for the default code width.
    localparam int unsigned MaxCode = (1 << DefaultQbits) - 1;

    typedef enum logic [1:0] {
        StFill,
        StFull,
        StResync
    } state_e;

    // Largest code representable in qbits bits.
    function automatic int unsigned max_code(input int unsigned qbits);
        return (1 << qbits) - 1;
    endfunction

endpackage

// File: rtl/hgcal_input_quantizer_if.sv
// Raw-beat input stream and packed-frame output stream of the input quantizer.
interface hgcal_input_quantizer_if #(
    parameter int unsigned IN_WIDTH     = 16,
    parameter int unsigned NUM_FEATURES = 48,
    parameter int unsigned QBITS        = 2
) ();

    logic                          in_valid;
    logic                          in_ready;
    logic [IN_WIDTH-1:0]           in_data;
    logic                          in_last;
    logic                          out_valid;
    logic                          out_ready;
    logic [NUM_FEATURES*QBITS-1:0] out_data;

    // Producer of raw beats and consumer of frames.
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data
    );

    // The quantizer itself.
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/hgcal_feature_quantizer.sv
// Combinational pedestal-subtract, right-shift and saturate for one raw cell energy.
module hgcal_feature_quantizer
    import hgcal_quant_pkg::*;
#(
    parameter int unsigned IN_WIDTH = DefaultInWidth,
    parameter int unsigned QBITS    = DefaultQbits,
    parameter int unsigned OFFSET   = 16,
    parameter int unsigned SHIFT    = 4
) (
    input  logic [IN_WIDTH-1:0] raw_i,
    output logic [QBITS-1:0]    code_o
);

    localparam logic [IN_WIDTH-1:0] MaxQ   = IN_WIDTH'(max_code(QBITS));
    localparam logic [IN_WIDTH-1:0] Offset = IN_WIDTH'(OFFSET);

    logic [IN_WIDTH-1:0] diff;
    logic [IN_WIDTH-1:0] scaled;

    // Clamp at zero below the pedestal, then saturate at the top code.
    always_comb begin
        diff   = (raw_i >= Offset) ? (raw_i - Offset) : '0;
        scaled = diff >> SHIFT;
        code_o = (scaled > MaxQ) ? MaxQ[QBITS-1:0] : scaled[QBITS-1:0];
    end

endmodule

// File: rtl/hgcal_input_quantizer.sv
// Quantizes a serial stream of cell energies and packs double-buffered frames for layer 0.
module hgcal_input_quantizer
    import hgcal_quant_pkg::*;
#(
    parameter int unsigned IN_WIDTH     = DefaultInWidth,
    parameter int unsigned NUM_FEATURES = DefaultNumFeatures,
    parameter int unsigned QBITS        = DefaultQbits,
    parameter int unsigned OFFSET       = 16,
    parameter int unsigned SHIFT        = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    hgcal_input_quantizer_if.slave       bus,
    output logic                         err_short,
    output logic                         err_long,
    output logic [15:0]                  frame_cnt
);

    localparam int unsigned           IdxW    = $clog2(NUM_FEATURES);
    localparam int unsigned           FrameW  = NUM_FEATURES * QBITS;
    localparam logic [IdxW-1:0]       LastIdx = IdxW'(NUM_FEATURES - 1);

    state_e              state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [FrameW-1:0]   asm_q, asm_d;
    logic [FrameW-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                err_short_q, err_short_d;
    logic                err_long_q, err_long_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;

    logic [QBITS-1:0]    code;
    logic                beat;
    logic                out_fire;
    logic                out_free;

    hgcal_feature_quantizer #(
        .IN_WIDTH (IN_WIDTH),
        .QBITS    (QBITS),
        .OFFSET   (OFFSET),
        .SHIFT    (SHIFT)
    ) u_quant (
        .raw_i  (bus.in_data),
        .code_o (code)
    );

    assign bus.in_ready  = (state_q != StFull);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign err_short     = err_short_q;
    assign err_long      = err_long_q;
    assign frame_cnt     = frame_cnt_q;

    assign beat     = bus.in_valid && bus.in_ready;
    assign out_fire = out_valid_q && bus.out_ready;
    // Output slot can take a new frame this cycle, including same-cycle handoff.
    assign out_free = !out_valid_q || bus.out_ready;

    // Next-state: beat assembly, frame handoff, error detection and frame counting.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        asm_d       = asm_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        frame_cnt_d = frame_cnt_q + {15'd0, out_fire};

        unique case (state_q)
            StFill: begin
                if (beat) begin
                    asm_d[idx_q*QBITS +: QBITS] = code;
                    if (idx_q == LastIdx) begin
                        idx_d = '0;
                        if (bus.in_last) begin
                            if (out_free) begin
                                out_data_d  = asm_d;
                                out_valid_d = 1'b1;
                            end else begin
                                state_d = StFull;
                            end
                        end else begin
                            err_long_d = 1'b1;
                            state_d    = StResync;
                        end
                    end else if (bus.in_last) begin
                        err_short_d = 1'b1;
                        idx_d       = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StFull: begin
                if (out_free) begin
                    out_data_d  = asm_q;
                    out_valid_d = 1'b1;
                    state_d     = StFill;
                end
            end
            StResync: begin
                // Drop beats silently until the end of the malformed frame.
                if (beat && bus.in_last) begin
                    idx_d   = '0;
                    state_d = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    // State and output registers; reset drops any partial or held frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StFill;
            idx_q       <= '0;
            asm_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            asm_q       <= asm_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_hgcal_input_quantizer.sv
// Directed self-checking bench for hgcal_input_quantizer.
module tb_hgcal_input_quantizer;

    localparam int unsigned N  = 48;
    localparam int unsigned Q  = 2;
    localparam int unsigned FW = N * Q;

    logic        clk;
    logic        rst_n;
    logic        err_short;
    logic        err_long;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    hgcal_input_quantizer_if #(.IN_WIDTH(16), .NUM_FEATURES(N), .QBITS(Q)) bus ();

    hgcal_input_quantizer #(
        .IN_WIDTH     (16),
        .NUM_FEATURES (N),
        .QBITS        (Q),
        .OFFSET       (16),
        .SHIFT        (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .err_short (err_short),
        .err_long  (err_long),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Hand-computed quantizer table (OFFSET=16, SHIFT=4, 2-bit codes).
    int unsigned raws  [5] = '{10, 40, 60, 100, 65535};
    int unsigned codes [5] = '{0, 1, 2, 3, 3};

    // Observations gathered by the monitor.
    logic [FW-1:0] got_q [$];
    int            fire_cyc_q [$];
    int            es_cnt = 0;
    int            el_cnt = 0;
    int            el_cyc = -1;
    int            ir_low = 0;
    logic          prev_hold = 1'b0;
    logic [FW-1:0] prev_data = '0;
    int            acc_cyc [64];

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] exp_frame(input int seed);
        logic [FW-1:0] f = '0;
        for (int i = 0; i < N; i++) f[i*Q +: Q] = Q'(codes[(i + seed) % 5]);
        return f;
    endfunction

    // Samples away from the active edge, after the negedge input updates settle.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (prev_hold && bus.out_valid) check("hold_stable", bus.out_data, prev_data);
            if (bus.out_valid && bus.out_ready) begin
                got_q.push_back(bus.out_data);
                fire_cyc_q.push_back(cyc);
            end
            if (err_short) es_cnt++;
            if (err_long) begin
                el_cnt++;
                el_cyc = cyc;
            end
            if (!bus.in_ready) ir_low++;
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic clear_obs();
        got_q.delete();
        fire_cyc_q.delete();
        es_cnt = 0;
        el_cnt = 0;
        el_cyc = -1;
        ir_low = 0;
    endtask

    // Presents one beat and holds it until accepted; records the launch cycle.
    task automatic send_beat(input logic [15:0] d, input logic l, output int acc);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            errors++;
            $display("FAIL beat_timeout observed=stalled expected=accepted");
        end
        acc = cyc;
    endtask

    task automatic send_frame(input int seed, input int len, input int last_at);
        int a;
        for (int b = 0; b < len; b++) begin
            send_beat(16'(raws[(b + seed) % 5]), (b == last_at - 1), a);
            acc_cyc[b] = a;
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    initial begin
        int b2b_last [3];

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // Reset state
        check("rst_out_valid", FW'(bus.out_valid), '0);
        check("rst_out_data", bus.out_data, '0);
        check("rst_err_short", FW'(err_short), '0);
        check("rst_err_long", FW'(err_long), '0);
        check("rst_frame_cnt", FW'(frame_cnt), '0);
        check("rst_in_ready", FW'(bus.in_ready), FW'(1));

        // Quantizer values and packing
        bus.out_ready = 1'b1;
        clear_obs();
        send_frame(0, N, N);
        idle(4);
        check("q_nframes", FW'(got_q.size()), FW'(1));
        if (got_q.size() > 0) begin
            check("q_low_codes", FW'(got_q[0][7:0]), FW'(8'hE4));
            check("q_sat_code", FW'(got_q[0][9:8]), FW'(3));
            check("q_frame", got_q[0], exp_frame(0));
            check("q_latency", FW'(fire_cyc_q[0]), FW'(acc_cyc[N-1] + 1));
        end
        check("q_frame_cnt", FW'(frame_cnt), FW'(1));

        // Back-to-back frames
        clear_obs();
        for (int f = 0; f < 3; f++) begin
            send_frame(f + 1, N, N);
            b2b_last[f] = acc_cyc[N-1];
        end
        idle(4);
        check("b2b_nframes", FW'(got_q.size()), FW'(3));
        for (int f = 0; f < 3; f++) begin
            if (f < got_q.size()) begin
                check("b2b_frame", got_q[f], exp_frame(f + 1));
                check("b2b_latency", FW'(fire_cyc_q[f]), FW'(b2b_last[f] + 1));
            end
        end
        check("b2b_frame_cnt", FW'(frame_cnt), FW'(4));
        check("b2b_in_ready", FW'(ir_low), '0);

        // Backpressure: two frames stack up, third frame's first beat stalls
        bus.out_ready = 1'b0;
        clear_obs();
        send_frame(4, N, N);
        send_frame(0, N, N);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd40;
        bus.in_last  = 1'b0;
        #1;
        check("bp_in_ready_97", FW'(bus.in_ready), '0);
        check("bp_out_valid", FW'(bus.out_valid), FW'(1));
        check("bp_held_data", bus.out_data, exp_frame(4));
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b1;
        idle(4);
        check("bp_nframes", FW'(got_q.size()), FW'(2));
        if (got_q.size() == 2) begin
            check("bp_first", got_q[0], exp_frame(4));
            check("bp_second", got_q[1], exp_frame(0));
        end
        check("bp_in_ready_after", FW'(bus.in_ready), FW'(1));
        check("bp_frame_cnt", FW'(frame_cnt), FW'(6));

        // Short frame then a good one
        clear_obs();
        send_frame(2, 20, 20);
        idle(3);
        check("short_err", FW'(es_cnt), FW'(1));
        check("short_no_out", FW'(got_q.size()), '0);
        send_frame(2, N, N);
        idle(3);
        check("short_next_n", FW'(got_q.size()), FW'(1));
        if (got_q.size() > 0) check("short_next_frame", got_q[0], exp_frame(2));
        check("short_err_once", FW'(es_cnt), FW'(1));
        check("short_no_long", FW'(el_cnt), '0);

        // Long frame then a good one
        clear_obs();
        send_frame(3, 60, 60);
        idle(3);
        check("long_err", FW'(el_cnt), FW'(1));
        check("long_err_time", FW'(el_cyc), FW'(acc_cyc[N-1] + 1));
        check("long_no_out", FW'(got_q.size()), '0);
        send_frame(1, N, N);
        idle(3);
        check("long_next_n", FW'(got_q.size()), FW'(1));
        if (got_q.size() > 0) check("long_next_frame", got_q[0], exp_frame(1));
        check("long_no_short", FW'(es_cnt), '0);

        // Reset with a held frame and a partial frame in flight
        bus.out_ready = 1'b0;
        clear_obs();
        send_frame(0, N, N);
        send_frame(3, 10, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", FW'(bus.out_valid), '0);
        check("mrst_frame_cnt", FW'(frame_cnt), '0);
        check("mrst_in_ready", FW'(bus.in_ready), FW'(1));
        check("mrst_out_data", bus.out_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        clear_obs();
        send_frame(1, N, N);
        idle(3);
        check("mrst_next_n", FW'(got_q.size()), FW'(1));
        if (got_q.size() > 0) check("mrst_next_frame", got_q[0], exp_frame(1));
        check("mrst_frame_cnt_after", FW'(frame_cnt), FW'(1));
        check("mrst_no_err", FW'(es_cnt + el_cnt), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
